// File: rtl/imm_gen_if.sv
// ---------------------------------------------------------------------------
// imm_gen_if
//   Bundle between the decode front end and the immediate generator.
//   Parameter XLEN sets the width of the immediate result.
//
//   master modport (instruction source / hazard unit side):
//     inst_in    out 32    instruction word
//     in_valid   out 1     inst_in holds a real instruction
//     stall      out 1     hold every stage
//     flush      out 1     kill every in-flight entry
//     imm_out    in  XLEN  sign-extended immediate
//     imm_fmt    in  3     decoded format code
//     out_valid  in  1     imm_out / imm_fmt are meaningful
//     illegal_op in  1     valid entry with an unsupported opcode
//   slave modport: same signals, opposite directions (immediate generator side).
// ---------------------------------------------------------------------------
interface imm_gen_if #(
  parameter int XLEN = 32
) ();
  logic [31:0]     inst_in;
  logic            in_valid;
  logic            stall;
  logic            flush;
  logic [XLEN-1:0] imm_out;
  logic [2:0]      imm_fmt;
  logic            out_valid;
  logic            illegal_op;

  modport master (
    output inst_in, in_valid, stall, flush,
    input  imm_out, imm_fmt, out_valid, illegal_op
  );

  modport slave (
    input  inst_in, in_valid, stall, flush,
    output imm_out, imm_fmt, out_valid, illegal_op
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe
//   Registered immediate generator for the RV32I/RV64I ID stage. Decodes the
//   I, S, B, U and J immediates from an instruction word, sign-extends them
//   to XLEN and carries {valid, imm, fmt} through a STAGES-deep pipeline
//   that obeys stall and flush (flush has priority over stall).
//
//   Parameters:
//     XLEN   32 | 64  immediate width (sign extension always from inst[31])
//     STAGES 1  | 2   register stages between inst_in and imm_out
//
//   Ports:
//     clk    in   rising-edge clock
//     reset  in   asynchronous, active-high reset (clears every stage)
//     bus    slave modport of imm_gen_if:
//              inst_in, in_valid, stall, flush    -> inputs
//              imm_out, imm_fmt, out_valid, illegal_op -> outputs
//
//   imm_fmt codes: 0 NONE (R-type), 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z, 7 ILLEGAL
//
//   Optional feature macro: IMM_GEN_ZICSR_EN
//     defined     : SYSTEM with funct3 in {101,110,111} yields fmt Z and the
//                   zero-extended 5-bit zimm from inst[19:15]; other SYSTEM
//                   funct3 values decode as fmt I.
//     not defined : every SYSTEM opcode decodes as fmt I; fmt Z never appears.
// ---------------------------------------------------------------------------
module imm_gen_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 1
) (
  input  logic     clk,
  input  logic     reset,
  imm_gen_if.slave bus
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] FMT_NONE    = 3'd0;
  localparam logic [2:0] FMT_I       = 3'd1;
  localparam logic [2:0] FMT_S       = 3'd2;
  localparam logic [2:0] FMT_B       = 3'd3;
  localparam logic [2:0] FMT_U       = 3'd4;
  localparam logic [2:0] FMT_J       = 3'd5;
  localparam logic [2:0] FMT_Z       = 3'd6;
  localparam logic [2:0] FMT_ILLEGAL = 3'd7;

  // Widen an already sign-extended 32-bit immediate to XLEN.
  function automatic logic signed [XLEN-1:0] sext32(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  // Zero-extend the 5-bit CSR zimm field to XLEN.
  function automatic logic signed [XLEN-1:0] zext5(input logic [4:0] v);
    return XLEN'(v);
  endfunction

  logic [31:0]            inst;
  logic [6:0]             opcode;
  logic signed [XLEN-1:0] dec_imm;
  logic [2:0]             dec_fmt;

  assign inst   = bus.inst_in;
  assign opcode = inst[6:0];

  // Combinational decode ahead of stage 0.
  always_comb begin
    dec_imm = '0;
    dec_fmt = FMT_ILLEGAL;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: begin
        dec_imm = sext32({{20{inst[31]}}, inst[31:20]});
        dec_fmt = FMT_I;
      end
      OP_STORE: begin
        dec_imm = sext32({{20{inst[31]}}, inst[31:25], inst[11:7]});
        dec_fmt = FMT_S;
      end
      OP_BRANCH: begin
        dec_imm = sext32({{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                          inst[11:8], 1'b0});
        dec_fmt = FMT_B;
      end
      OP_LUI, OP_AUIPC: begin
        dec_imm = sext32({inst[31:12], 12'b0});
        dec_fmt = FMT_U;
      end
      OP_JAL: begin
        dec_imm = sext32({{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                          inst[30:21], 1'b0});
        dec_fmt = FMT_J;
      end
      OP_REG: begin
        dec_imm = '0;
        dec_fmt = FMT_NONE;
      end
      OP_SYSTEM: begin
`ifdef IMM_GEN_ZICSR_EN
        // funct3 101/110/111 are the immediate CSR forms (CSRRWI/SI/CI).
        if (inst[14] && (inst[13:12] != 2'b00)) begin
          dec_imm = zext5(inst[19:15]);
          dec_fmt = FMT_Z;
        end else begin
          dec_imm = sext32({{20{inst[31]}}, inst[31:20]});
          dec_fmt = FMT_I;
        end
`else
        dec_imm = sext32({{20{inst[31]}}, inst[31:20]});
        dec_fmt = FMT_I;
`endif
      end
      default: begin
        dec_imm = '0;
        dec_fmt = FMT_ILLEGAL;
      end
    endcase
  end

  // ---- stage 0 boundary ----
  logic                   vld_p0;
  logic signed [XLEN-1:0] imm_p0;
  logic [2:0]             fmt_p0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      imm_p0 <= '0;
      fmt_p0 <= FMT_NONE;
    end else if (bus.flush) begin
      vld_p0 <= 1'b0;
    end else if (!bus.stall) begin
      vld_p0 <= bus.in_valid;
      imm_p0 <= dec_imm;
      fmt_p0 <= dec_fmt;
    end
  end

  logic                   vld_last;
  logic signed [XLEN-1:0] imm_last;
  logic [2:0]             fmt_last;

  generate
    if (STAGES >= 2) begin : g_two_stage
      // ---- stage 1 boundary ----
      logic                   vld_p1;
      logic signed [XLEN-1:0] imm_p1;
      logic [2:0]             fmt_p1;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          vld_p1 <= 1'b0;
          imm_p1 <= '0;
          fmt_p1 <= FMT_NONE;
        end else if (bus.flush) begin
          vld_p1 <= 1'b0;
        end else if (!bus.stall) begin
          vld_p1 <= vld_p0;
          imm_p1 <= imm_p0;
          fmt_p1 <= fmt_p0;
        end
      end

      assign vld_last = vld_p1;
      assign imm_last = imm_p1;
      assign fmt_last = fmt_p1;
    end else begin : g_one_stage
      assign vld_last = vld_p0;
      assign imm_last = imm_p0;
      assign fmt_last = fmt_p0;
    end
  endgenerate

  // ---- output boundary ----
  // Outputs are masked by valid so a bubble never shows stale data.
  assign bus.out_valid  = vld_last;
  assign bus.imm_out    = vld_last ? imm_last : '0;
  assign bus.imm_fmt    = vld_last ? fmt_last : FMT_NONE;
  assign bus.illegal_op = vld_last && (fmt_last == FMT_ILLEGAL);

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imm_gen_if #(.XLEN(32)) ifa ();
  imm_gen_if #(.XLEN(64)) ifb ();

  imm_gen_pipe #(.XLEN(32), .STAGES(1)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  imm_gen_pipe #(.XLEN(64), .STAGES(2)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] inst;
    logic        in_valid;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        vld;
    logic        ill;
  } vec_t;

  vec_t vecs[15];

  localparam logic [31:0] I_ADDI = 32'hFFF00093;
  localparam logic [31:0] I_SW   = 32'hFE112E23;
  localparam logic [31:0] I_LUI  = 32'h123452B7;
  localparam logic [31:0] I_JAL  = 32'h001000EF;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic chk_a(input string n, input logic [31:0] imm, input logic [2:0] fmt,
                       input logic vld, input logic ill);
    chk({n, "_imm"}, 64'(ifa.imm_out), 64'(imm));
    chk({n, "_fmt"}, 64'(ifa.imm_fmt), 64'(fmt));
    chk({n, "_vld"}, 64'(ifa.out_valid), 64'(vld));
    chk({n, "_ill"}, 64'(ifa.illegal_op), 64'(ill));
  endtask

  task automatic chk_b(input string n, input logic [63:0] imm, input logic [2:0] fmt,
                       input logic vld, input logic ill);
    chk({n, "_imm"}, ifb.imm_out, imm);
    chk({n, "_fmt"}, 64'(ifb.imm_fmt), 64'(fmt));
    chk({n, "_vld"}, 64'(ifb.out_valid), 64'(vld));
    chk({n, "_ill"}, 64'(ifb.illegal_op), 64'(ill));
  endtask

  // Apply one cycle of stimulus to the two-stage 64-bit instance and sample
  // just after the capturing edge.
  task automatic drive_b(input logic [31:0] inst, input logic v, input logic st,
                         input logic fl);
    @(negedge clk);
    ifb.inst_in  = inst;
    ifb.in_valid = v;
    ifb.stall    = st;
    ifb.flush    = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{I_ADDI,       1'b1, 32'hFFFFFFFF, 3'd1, 1'b1, 1'b0};
    vecs[1]  = '{I_SW,         1'b1, 32'hFFFFFFFC, 3'd2, 1'b1, 1'b0};
    vecs[2]  = '{32'hFE000CE3, 1'b1, 32'hFFFFFFF8, 3'd3, 1'b1, 1'b0};
    vecs[3]  = '{I_LUI,        1'b1, 32'h12345000, 3'd4, 1'b1, 1'b0};
    vecs[4]  = '{I_JAL,        1'b1, 32'h00000800, 3'd5, 1'b1, 1'b0};
    vecs[5]  = '{I_BAD,        1'b1, 32'h00000000, 3'd7, 1'b1, 1'b1};
    vecs[6]  = '{I_BAD,        1'b0, 32'h00000000, 3'd0, 1'b0, 1'b0};
    vecs[7]  = '{32'h002081B3, 1'b1, 32'h00000000, 3'd0, 1'b1, 1'b0};
    vecs[8]  = '{32'h0080A283, 1'b1, 32'h00000008, 3'd1, 1'b1, 1'b0};
    vecs[9]  = '{32'hFFFFF097, 1'b1, 32'hFFFFF000, 3'd4, 1'b1, 1'b0};
    vecs[10] = '{32'h7FF08067, 1'b1, 32'h000007FF, 3'd1, 1'b1, 1'b0};
    vecs[11] = '{32'h800000EF, 1'b1, 32'hFFF00000, 3'd5, 1'b1, 1'b0};
`ifdef IMM_GEN_ZICSR_EN
    vecs[12] = '{32'h3401D073, 1'b1, 32'h00000003, 3'd6, 1'b1, 1'b0};
`else
    vecs[12] = '{32'h3401D073, 1'b1, 32'h00000340, 3'd1, 1'b1, 1'b0};
`endif
    vecs[13] = '{32'hFFFFFFFF, 1'b0, 32'h00000000, 3'd0, 1'b0, 1'b0};
    vecs[14] = '{32'h0000000F, 1'b1, 32'h00000000, 3'd7, 1'b1, 1'b1};

    reset        = 1'b1;
    ifa.inst_in  = '0; ifa.in_valid = 1'b0; ifa.stall = 1'b0; ifa.flush = 1'b0;
    ifb.inst_in  = '0; ifb.in_valid = 1'b0; ifb.stall = 1'b0; ifb.flush = 1'b0;
    #2;
    chk_a("rst_a", 32'h0, 3'd0, 1'b0, 1'b0);
    chk_b("rst_b", 64'h0, 3'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Single-stage 32-bit table: response one edge after the input.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      ifa.inst_in  = vecs[i].inst;
      ifa.in_valid = vecs[i].in_valid;
      @(posedge clk);
      #1;
      chk_a($sformatf("vec%0d", i), vecs[i].imm, vecs[i].fmt, vecs[i].vld, vecs[i].ill);
    end
    @(negedge clk);
    ifa.in_valid = 1'b0;

    // Two-stage 64-bit: exact latency and 64-bit sign extension.
    drive_b(I_ADDI, 1'b1, 1'b0, 1'b0);
    chk_b("lat1", 64'h0, 3'd0, 1'b0, 1'b0);
    drive_b('0, 1'b0, 1'b0, 1'b0);
    chk_b("addi64", 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b1, 1'b0);
    drive_b('0, 1'b0, 1'b0, 1'b0);
    chk_b("bubble0", 64'h0, 3'd0, 1'b0, 1'b0);

    // Stream A,B,C with a two-cycle stall while B sits in stage 0.
    drive_b(I_LUI, 1'b1, 1'b0, 1'b0);
    drive_b(I_SW,  1'b1, 1'b0, 1'b0);
    chk_b("strA", 64'h12345000, 3'd4, 1'b1, 1'b0);
    drive_b(I_JAL, 1'b1, 1'b1, 1'b0);
    chk_b("stl1", 64'h12345000, 3'd4, 1'b1, 1'b0);
    drive_b(I_JAL, 1'b1, 1'b1, 1'b0);
    chk_b("stl2", 64'h12345000, 3'd4, 1'b1, 1'b0);
    drive_b(I_JAL, 1'b1, 1'b0, 1'b0);
    chk_b("strB", 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b1, 1'b0);
    drive_b('0, 1'b0, 1'b0, 1'b0);
    chk_b("strC", 64'h800, 3'd5, 1'b1, 1'b0);
    drive_b('0, 1'b0, 1'b0, 1'b0);
    chk_b("strEnd", 64'h0, 3'd0, 1'b0, 1'b0);

    // Illegal pulse held high while stalled.
    drive_b(I_BAD, 1'b1, 1'b0, 1'b0);
    drive_b('0, 1'b0, 1'b0, 1'b0);
    chk_b("ill", 64'h0, 3'd7, 1'b1, 1'b1);
    drive_b('0, 1'b0, 1'b1, 1'b0);
    chk_b("illHold", 64'h0, 3'd7, 1'b1, 1'b1);
    drive_b('0, 1'b0, 1'b0, 1'b0);
    chk_b("illGone", 64'h0, 3'd0, 1'b0, 1'b0);

    // Flush together with stall: flush wins, stalled bubbles stay invalid.
    drive_b(I_LUI, 1'b1, 1'b0, 1'b0);
    drive_b(I_SW,  1'b1, 1'b0, 1'b0);
    chk_b("preFl", 64'h12345000, 3'd4, 1'b1, 1'b0);
    drive_b(I_JAL, 1'b1, 1'b1, 1'b1);
    chk_b("flSt", 64'h0, 3'd0, 1'b0, 1'b0);
    drive_b(I_JAL, 1'b1, 1'b1, 1'b0);
    chk_b("flSt2", 64'h0, 3'd0, 1'b0, 1'b0);
    drive_b('0, 1'b0, 1'b0, 1'b0);
    chk_b("flSt3", 64'h0, 3'd0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a stream.
    drive_b(I_LUI, 1'b1, 1'b0, 1'b0);
    drive_b(I_SW,  1'b1, 1'b0, 1'b0);
    chk_b("preRst", 64'h12345000, 3'd4, 1'b1, 1'b0);
    @(negedge clk);
    ifb.in_valid = 1'b0;
    reset        = 1'b1;
    #1;
    chk_b("rstAsync", 64'h0, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_b("rstAfter", 64'h0, 3'd0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
